// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared encodings, FSM state type and operand-select helper for serial_au
// Contents:
//   AU_XFER/AU_ADD/AU_SUB/AU_DEC : 2-bit operation select encodings
//   au_state_e                   : IDLE/RUN/DONE state type
//   au_beff_bit()                : one bit of the effective B operand for a given select
package au_pkg;

    localparam logic [1:0] AU_XFER = 2'b00;  // Beff = 0
    localparam logic [1:0] AU_ADD  = 2'b01;  // Beff = B
    localparam logic [1:0] AU_SUB  = 2'b10;  // Beff = ~B
    localparam logic [1:0] AU_DEC  = 2'b11;  // Beff = all ones

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } au_state_e;

    function automatic logic au_beff_bit(input logic b, input logic [1:0] s);
        case (s)
            AU_XFER: return 1'b0;
            AU_ADD:  return b;
            AU_SUB:  return ~b;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/serial_au_if.sv
// rtl/serial_au_if.sv - operand/result handshake bundle for serial_au
// Signals:
//   in_valid/in_ready   : operation handshake (A, B, cin, S qualified by in_valid)
//   out_valid/out_ready : result handshake (D, cout, Z, N, V qualified by out_valid)
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : serial_au side (drives in_ready and result)
interface serial_au_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic [1:0]       S;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             cout;
    logic             Z;
    logic             N;
    logic             V;

    modport master (
        output in_valid, A, B, cin, S, out_ready,
        input  in_ready, out_valid, D, cout, Z, N, V
    );

    modport slave (
        input  in_valid, A, B, cin, S, out_ready,
        output in_ready, out_valid, D, cout, Z, N, V
    );

endinterface

// File: rtl/au_digit.sv
// rtl/au_digit.sv - combinational DIGIT-wide slice of the add/sub datapath
// Ports:
//   a_i  : A digit          b_i : B digit (raw, select applied here)
//   c_i  : carry into digit s_i : operation select
//   d_o  : result digit     c_o : carry out of digit
module au_digit
    import au_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    input  logic [1:0]       s_i,
    output logic [DIGIT-1:0] d_o,
    output logic             c_o
);

    logic [DIGIT-1:0] beff;
    logic [DIGIT:0]   sum;

    always_comb begin
        beff = '0;
        for (int i = 0; i < DIGIT; i++) begin
            beff[i] = au_beff_bit(b_i[i], s_i);
        end
        sum = {1'b0, a_i} + {1'b0, beff} + {{DIGIT{1'b0}}, c_i};
    end

    assign d_o = sum[DIGIT-1:0];
    assign c_o = sum[DIGIT];

endmodule

// File: rtl/serial_au.sv
// rtl/serial_au.sv - digit-serial add/sub/transfer/decrement unit, one DIGIT per cycle
// Ports:
//   clk : clock (rising edge)
//   rst : synchronous active-high reset
//   bus : serial_au_if.slave - operand handshake in, result handshake and flags out
module serial_au
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_au_if.slave       bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB  = WIDTH - 1;

    au_state_e        state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       s_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] acc_q;   // working result; D only updates on the final digit
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] d_q;
    logic             cout_q;
    logic             z_q;
    logic             n_q;
    logic             v_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_d;
    logic             dig_cout;
    logic             beff_msb;
    int               base;

    always_comb begin
        base  = int'(k_q) * DIGIT;
        dig_a = a_q[base +: DIGIT];
        dig_b = b_q[base +: DIGIT];
        acc_d = acc_q;
        acc_d[base +: DIGIT] = dig_d;
    end

    au_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i (dig_a),
        .b_i (dig_b),
        .c_i (carry_q),
        .s_i (s_q),
        .d_o (dig_d),
        .c_o (dig_cout)
    );

    assign beff_msb = au_beff_bit(b_q[MSB], s_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= AU_XFER;
            carry_q     <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            cout_q      <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.A;
                        b_q        <= bus.B;
                        s_q        <= bus.S;
                        carry_q    <= bus.cin;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= dig_cout;
                    k_q     <= k_q + KW'(1);
                    if (k_q == KW'(NDIG - 1)) begin
                        // Last digit: publish the full result and flags together.
                        d_q         <= acc_d;
                        cout_q      <= dig_cout;
                        z_q         <= (acc_d == '0);
                        n_q         <= acc_d[MSB];
                        v_q         <= (a_q[MSB] == beff_msb) && (acc_d[MSB] != a_q[MSB]);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.cout      = cout_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.V         = v_q;

endmodule

// File: tb/tb_serial_au.sv
// tb/tb_serial_au.sv - self-checking bench for serial_au (16/4 and 8/8 configurations)
module tb_serial_au;
    import au_pkg::*;

    typedef struct {
        longint d;
        bit     cout;
        bit     z;
        bit     n;
        bit     v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    serial_au_if #(.WIDTH(16)) bus16();
    serial_au_if #(.WIDTH(8))  bus8();

    serial_au #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(bus16));
    serial_au #(.WIDTH(8),  .DIGIT(8)) u8  (.clk(clk), .rst(rst), .bus(bus8));

    function automatic res_t model(input int w, input longint a, input longint b,
                                   input bit c, input bit [1:0] s);
        res_t   r;
        longint mask = (64'd1 << w) - 1;
        longint beff;
        longint sum;
        bit     am;
        bit     bm;
        case (s)
            2'b00:   beff = 0;
            2'b01:   beff = b & mask;
            2'b10:   beff = (~b) & mask;
            default: beff = mask;
        endcase
        sum    = (a & mask) + beff + longint'(c);
        r.d    = sum & mask;
        r.cout = bit'((sum >> w) & 1);
        r.z    = (r.d == 0);
        r.n    = bit'((r.d >> (w - 1)) & 1);
        am     = bit'((a >> (w - 1)) & 1);
        bm     = bit'((beff >> (w - 1)) & 1);
        r.v    = (am == bm) && (r.n != am);
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res16(input string tag, input res_t e);
        chk({tag, "_d"},    longint'(bus16.D), e.d);
        chk({tag, "_cout"}, longint'(bus16.cout), longint'(e.cout));
        chk({tag, "_z"},    longint'(bus16.Z), longint'(e.z));
        chk({tag, "_n"},    longint'(bus16.N), longint'(e.n));
        chk({tag, "_v"},    longint'(bus16.V), longint'(e.v));
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [1:0] s, input int hold);
        res_t e;
        int   n;
        int   lat;
        e = model(16, longint'(a), longint'(b), c, s);
        n = 0;
        while (!bus16.in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("in_ready_idle", longint'(bus16.in_ready), 1);
        bus16.A = a; bus16.B = b; bus16.cin = c; bus16.S = s;
        bus16.in_valid = 1'b1;
        tick;
        bus16.in_valid = 1'b0;
        chk("in_ready_busy", longint'(bus16.in_ready), 0);
        lat = 0;
        while (lat < 20) begin
            // operands scrambled while the captured ones are being processed
            bus16.A   = 16'($urandom);
            bus16.B   = 16'($urandom);
            bus16.cin = 1'($urandom);
            bus16.S   = 2'($urandom);
            tick;
            lat++;
            if (bus16.out_valid) break;
        end
        chk("latency", longint'(lat), 4);
        chk_res16("res", e);
        for (int i = 0; i < hold; i++) begin
            bus16.A        = 16'($urandom);
            bus16.B        = 16'($urandom);
            bus16.in_valid = (i % 2 == 0);
            tick;
            chk("hold_valid", longint'(bus16.out_valid), 1);
            chk("hold_ready", longint'(bus16.in_ready), 0);
            chk_res16("hold", e);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        tick;
        bus16.out_ready = 1'b0;
        chk("post_valid", longint'(bus16.out_valid), 0);
        chk("post_ready", longint'(bus16.in_ready), 1);
        chk_res16("post", e);
    endtask

    initial begin
        res_t e8;
        int   lat;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.A = '0; bus16.B = '0; bus16.cin = 1'b0; bus16.S = 2'b00;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.A = '0; bus8.B = '0; bus8.cin = 1'b0; bus8.S = 2'b00;

        rst = 1'b1;
        tick;
        tick;
        chk("rst_in_ready",  longint'(bus16.in_ready), 1);
        chk("rst_out_valid", longint'(bus16.out_valid), 0);
        chk_res16("rst", '{d: 0, cout: 0, z: 0, n: 0, v: 0});
        chk("rst8_in_ready",  longint'(bus8.in_ready), 1);
        chk("rst8_out_valid", longint'(bus8.out_valid), 0);
        chk("rst8_d",         longint'(bus8.D), 0);
        rst = 1'b0;
        tick;

        op16(16'h00FF, 16'h0001, 1'b0, AU_ADD,  0);
        op16(16'h1234, 16'h1234, 1'b1, AU_SUB,  0);
        op16(16'h7FFF, 16'h0001, 1'b0, AU_ADD,  0);
        op16(16'h0000, 16'($urandom), 1'b0, AU_DEC,  0);
        op16(16'hFFFF, 16'($urandom), 1'b1, AU_XFER, 0);
        op16(16'hA5A5, 16'h5A5A, 1'b0, AU_ADD,  3);

        for (int i = 0; i < 25; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
                 int'($urandom_range(0, 2)));
        end

        // abort: leave a nonzero result, then reset on the second RUN cycle
        op16(16'h7FFF, 16'h0001, 1'b0, AU_ADD, 0);
        bus16.A = 16'h1111; bus16.B = 16'h2222; bus16.cin = 1'b0; bus16.S = AU_ADD;
        bus16.in_valid = 1'b1;
        tick;
        bus16.in_valid = 1'b0;
        chk("abort_run1_valid", longint'(bus16.out_valid), 0);
        tick;
        chk("abort_run2_valid", longint'(bus16.out_valid), 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_in_ready",  longint'(bus16.in_ready), 1);
        chk("abort_out_valid", longint'(bus16.out_valid), 0);
        chk_res16("abort", '{d: 0, cout: 0, z: 0, n: 0, v: 0});
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_no_pulse", longint'(bus16.out_valid), 0);
        end

        // single-digit configuration
        e8 = model(8, 64'h80, 64'h80, 1'b0, AU_ADD);
        bus8.A = 8'h80; bus8.B = 8'h80; bus8.cin = 1'b0; bus8.S = AU_ADD;
        bus8.in_valid = 1'b1;
        tick;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick;
            lat++;
            if (bus8.out_valid) break;
        end
        chk("lat8",  longint'(lat), 1);
        chk("d8",    longint'(bus8.D), e8.d);
        chk("cout8", longint'(bus8.cout), longint'(e8.cout));
        chk("v8",    longint'(bus8.V), longint'(e8.v));
        chk("z8",    longint'(bus8.Z), longint'(e8.z));
        chk("n8",    longint'(bus8.N), longint'(e8.n));
        bus8.out_ready = 1'b1;
        tick;
        bus8.out_ready = 1'b0;
        chk("post8_valid", longint'(bus8.out_valid), 0);
        chk("post8_ready", longint'(bus8.in_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
